// File: rtl/final_logic.sv
// rtl/final_logic.sv - VC-to-destination router with strict VC0 priority and sticky error FSM
// Optional feature macro: FINAL_LOGIC_COUNTERS_EN (adds per-destination 8-bit push counters)
module final_logic #(
  parameter int data_width = 6,
  parameter int route_bit  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [data_width-1:0] data_in_VC0,
  input  logic                  empty_fifo_VC0,
  input  logic [data_width-1:0] data_in_VC1,
  input  logic                  empty_fifo_VC1,
  input  logic                  almost_full_fifo_D0,
  input  logic                  almost_full_fifo_D1,
  input  logic                  full_fifo_D0,
  input  logic                  full_fifo_D1,
  output logic                  pop_VC0_fifo,
  output logic                  pop_VC1_fifo,
  output logic                  push_D0,
  output logic                  push_D1,
  output logic [data_width-1:0] data_out_D0,
  output logic [data_width-1:0] data_out_D1,
`ifdef FINAL_LOGIC_COUNTERS_EN
  output logic [7:0]            count_D0,
  output logic [7:0]            count_D1,
`endif
  output logic                  idle_out,
  output logic                  active_out,
  output logic                  error_out
);

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_ERROR  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic                  push0_q, push0_d;
  logic                  push1_q, push1_d;
  logic [data_width-1:0] data0_q, data0_d;
  logic [data_width-1:0] data1_q, data1_d;

  logic                  can_pop;
  logic                  vc0_ok;
  logic                  vc1_ok;
  logic                  pop0;
  logic                  pop1;
  logic [data_width-1:0] sel_word;
  logic                  err_hit;

  // Arbitration: a VC is eligible when non-empty and its head's destination is not almost full;
  // VC1 may only go when VC0 is empty, so a blocked VC0 holds the line.
  always_comb begin
    can_pop  = (state_q == ST_IDLE) || (state_q == ST_ACTIVE);
    vc0_ok   = !empty_fifo_VC0 &&
               !(data_in_VC0[route_bit] ? almost_full_fifo_D1 : almost_full_fifo_D0);
    vc1_ok   = !empty_fifo_VC1 &&
               !(data_in_VC1[route_bit] ? almost_full_fifo_D1 : almost_full_fifo_D0);
    pop0     = can_pop && vc0_ok;
    pop1     = can_pop && empty_fifo_VC0 && vc1_ok;
    sel_word = pop0 ? data_in_VC0 : data_in_VC1;
    err_hit  = (push0_q && full_fifo_D0) || (push1_q && full_fifo_D1);
  end

  // Datapath next values: the popped word is steered by its route bit and held otherwise
  always_comb begin
    push0_d = (pop0 || pop1) && !sel_word[route_bit];
    push1_d = (pop0 || pop1) &&  sel_word[route_bit];
    data0_d = push0_d ? sel_word : data0_q;
    data1_d = push1_d ? sel_word : data1_q;
  end

  // Next-state logic; a push into a full destination wins over every other transition
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET:  state_d = ST_IDLE;
      ST_IDLE:   if (!empty_fifo_VC0 || !empty_fifo_VC1) state_d = ST_ACTIVE;
      ST_ACTIVE: if (empty_fifo_VC0 && empty_fifo_VC1 && !push0_q && !push1_q) state_d = ST_IDLE;
      ST_ERROR:  state_d = ST_ERROR;
      default:   state_d = ST_RESET;
    endcase
    if (state_q != ST_RESET && err_hit) state_d = ST_ERROR;
  end

  // State and datapath registers; reset discards any push in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RESET;
      push0_q <= 1'b0;
      push1_q <= 1'b0;
      data0_q <= '0;
      data1_q <= '0;
    end else begin
      state_q <= state_d;
      push0_q <= push0_d;
      push1_q <= push1_d;
      data0_q <= data0_d;
      data1_q <= data1_d;
    end
  end

  // Output decode from state plus the combinational pop strobes
  always_comb begin
    pop_VC0_fifo = pop0;
    pop_VC1_fifo = pop1;
    push_D0      = push0_q;
    push_D1      = push1_q;
    data_out_D0  = data0_q;
    data_out_D1  = data1_q;
    idle_out     = (state_q == ST_IDLE);
    active_out   = (state_q == ST_ACTIVE);
    error_out    = (state_q == ST_ERROR);
  end

`ifdef FINAL_LOGIC_COUNTERS_EN
  logic [7:0] cnt0_q, cnt0_d;
  logic [7:0] cnt1_q, cnt1_d;

  // Push counters wrap naturally at 8 bits
  always_comb begin
    cnt0_d = push0_q ? cnt0_q + 8'd1 : cnt0_q;
    cnt1_d = push1_q ? cnt1_q + 8'd1 : cnt1_q;
  end

  // Counter registers, cleared by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt0_q <= 8'd0;
      cnt1_q <= 8'd0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign count_D0 = cnt0_q;
  assign count_D1 = cnt1_q;
`endif

endmodule
